// File: rtl/miss_fill_unit_pkg.sv
// Shared types and constants for the dcache miss fill path.
package miss_fill_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    READ,
    DONE
  } fill_state_t;

  localparam int BLKWORDS_DEF = 2;
  localparam int BLKOFF_W     = $clog2(BLKWORDS_DEF * 4);

endpackage

// File: rtl/miss_fill_if.sv
// Bundle of miss fill unit signals; mf is the unit's view, tb the requester/memory view.
interface miss_fill_if
  import miss_fill_unit_pkg::*;
#(
  parameter int BLKWORDS = BLKWORDS_DEF
) (
  input logic CLK
);

  logic                    nRST;
  logic                    fill_req;
  word_t                   fill_addr;
  logic                    fill_busy;
  logic                    fill_ready;
  logic [32*BLKWORDS-1:0]  fill_data;
  logic                    wempty;
  logic                    wq_hit;
  logic                    dmissREN;
  logic                    dREN;
  word_t                   daddr;
  word_t                   dload;
  logic                    dwait;

  modport mf (
    input  CLK, nRST, fill_req, fill_addr, wempty, wq_hit, dload, dwait,
    output fill_busy, fill_ready, fill_data, dmissREN, dREN, daddr
  );

  modport tb (
    input  CLK, fill_busy, fill_ready, fill_data, dmissREN, dREN, daddr,
    output nRST, fill_req, fill_addr, wempty, wq_hit, dload, dwait
  );

endinterface

// File: rtl/miss_fill_unit.sv
// Services dcache read misses: waits for the write queue, then reads a whole block from memory.
// Optional MISS_BYPASS_EN lets a miss skip the drain when the queue holds nothing for its block.
module miss_fill_unit
  import miss_fill_unit_pkg::*;
#(
  parameter int BLKWORDS = BLKWORDS_DEF
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   fill_req,
  input  logic [31:0]            fill_addr,
  output logic                   fill_busy,
  output logic                   fill_ready,
  output logic [32*BLKWORDS-1:0] fill_data,
  input  logic                   wempty,
  input  logic                   wq_hit,
  output logic                   dmissREN,
  output logic                   dREN,
  output logic [31:0]            daddr,
  input  logic [31:0]            dload,
  input  logic                   dwait
);

  localparam int               OFF_W    = $clog2(BLKWORDS) + 2;
  localparam int               CNT_W    = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(BLKWORDS - 1);
  localparam word_t            OFF_MASK = word_t'((1 << OFF_W) - 1);

  fill_state_t      state, next_state;
  logic [CNT_W-1:0] cnt;
  word_t            base;
  logic             go_read;

`ifdef MISS_BYPASS_EN
  assign go_read = wempty | ~wq_hit;
`else
  logic unused_wq_hit;
  assign unused_wq_hit = wq_hit;
  assign go_read       = wempty;
`endif

  always_comb begin
    next_state = state;
    fill_busy  = (state != IDLE);
    fill_ready = 1'b0;
    dREN       = 1'b0;
    dmissREN   = 1'b0;
    daddr      = '0;
    unique case (state)
      IDLE:  if (fill_req) next_state = go_read ? READ : DRAIN;
      DRAIN: if (go_read) next_state = READ;
      READ: begin
        dREN     = 1'b1;
        dmissREN = 1'b1;
        daddr    = base + (word_t'(cnt) << 2);
        if (!dwait && cnt == LAST) next_state = DONE;
      end
      DONE: begin
        fill_ready = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The counter parks on the last word; the next request clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      fill_data <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (fill_req) begin
            base <= fill_addr & ~OFF_MASK;
            cnt  <= '0;
          end
        end
        READ: begin
          if (!dwait) begin
            fill_data[32*cnt +: 32] <= dload;
            if (cnt != LAST) cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miss_fill_unit.sv
// Self-checking bench for miss_fill_unit: directed fills plus randomized fills against a block-level model.
module tb_miss_fill_unit;
  import miss_fill_unit_pkg::*;

  localparam int BLK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  miss_fill_if #(.BLKWORDS(BLK)) mif (.CLK(clk));

  miss_fill_unit #(.BLKWORDS(BLK)) dut (
    .CLK        (clk),
    .nRST       (mif.nRST),
    .fill_req   (mif.fill_req),
    .fill_addr  (mif.fill_addr),
    .fill_busy  (mif.fill_busy),
    .fill_ready (mif.fill_ready),
    .fill_data  (mif.fill_data),
    .wempty     (mif.wempty),
    .wq_hit     (mif.wq_hit),
    .dmissREN   (mif.dmissREN),
    .dREN       (mif.dREN),
    .daddr      (mif.daddr),
    .dload      (mif.dload),
    .dwait      (mif.dwait)
  );

  int checks = 0;
  int errors = 0;
  logic [32*BLK-1:0] last_data = '0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete fill: drain phase of 'drain' queue-busy cycles, then the block read.
  // wait_mode: 0 no memory waits, 1 random waits, 2 three waits on word 0.
  task automatic run_fill(input word_t addr, input int drain, input logic hit, input int wait_mode,
                          input bit fixed, input word_t w0, input word_t w1);
    word_t             words [BLK];
    logic [32*BLK-1:0] exp_data;
    word_t             base;
    int                eff_drain;
    int                k;
    int                nwait;
    base = addr & ~word_t'(BLK * 4 - 1);
    for (int i = 0; i < BLK; i++) begin
      words[i] = $urandom;
    end
    if (fixed) begin
      words[0]     = w0;
      words[BLK-1] = w1;
    end
    for (int i = 0; i < BLK; i++) begin
      exp_data[32*i +: 32] = words[i];
    end
    eff_drain = drain;
`ifdef MISS_BYPASS_EN
    if (!hit) eff_drain = 0;
`endif

    @(negedge clk);
    mif.fill_req  = 1'b1;
    mif.fill_addr = addr;
    mif.wempty    = (drain == 0);
    mif.wq_hit    = hit;
    mif.dwait     = 1'($urandom_range(0, 1));
    mif.dload     = $urandom;
    #1;
    check_output("req_busy", 64'(mif.fill_busy), 64'd0);
    check_output("req_dren", 64'(mif.dREN), 64'd0);

    for (int c = 1; c <= eff_drain; c++) begin
      @(negedge clk);
      mif.fill_addr = $urandom;
      mif.wempty    = (c >= drain);
      mif.wq_hit    = hit;
      #1;
      check_output("drain_busy", 64'(mif.fill_busy), 64'd1);
      check_output("drain_dren", 64'(mif.dREN), 64'd0);
      check_output("drain_dmissren", 64'(mif.dmissREN), 64'd0);
      check_output("drain_ready", 64'(mif.fill_ready), 64'd0);
    end

    k = 0;
    nwait = 0;
    while (k < BLK) begin
      @(negedge clk);
      mif.fill_addr = $urandom;
      mif.wempty    = 1'($urandom_range(0, 1));
      mif.wq_hit    = 1'($urandom_range(0, 1));
      case (wait_mode)
        1:       mif.dwait = (nwait < 8) && ($urandom_range(0, 2) == 0);
        2:       mif.dwait = (k == 0) && (nwait < 3);
        default: mif.dwait = 1'b0;
      endcase
      mif.dload = mif.dwait ? $urandom : words[k];
      #1;
      check_output("read_dren", 64'(mif.dREN), 64'd1);
      check_output("read_dmissren", 64'(mif.dmissREN), 64'd1);
      check_output("read_daddr", 64'(mif.daddr), 64'(base + word_t'(4 * k)));
      check_output("read_ready", 64'(mif.fill_ready), 64'd0);
      if (mif.dwait) nwait++;
      else k++;
    end

    @(negedge clk);
    mif.fill_req  = 1'b0;
    mif.fill_addr = $urandom;
    mif.dwait     = 1'($urandom_range(0, 1));
    #1;
    check_output("done_ready", 64'(mif.fill_ready), 64'd1);
    check_output("done_data", 64'(mif.fill_data), 64'(exp_data));
    check_output("done_dren", 64'(mif.dREN), 64'd0);
    check_output("done_dmissren", 64'(mif.dmissREN), 64'd0);
    last_data = exp_data;
  endtask

  task automatic idle_check();
    @(negedge clk);
    mif.fill_req = 1'b0;
    #1;
    check_output("idle_busy", 64'(mif.fill_busy), 64'd0);
    check_output("idle_ready", 64'(mif.fill_ready), 64'd0);
    check_output("idle_hold_data", 64'(mif.fill_data), 64'(last_data));
  endtask

  initial begin
    mif.nRST      = 1'b0;
    mif.fill_req  = 1'b0;
    mif.fill_addr = '0;
    mif.wempty    = 1'b1;
    mif.wq_hit    = 1'b0;
    mif.dload     = '0;
    mif.dwait     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_busy", 64'(mif.fill_busy), 64'd0);
    check_output("rst_ready", 64'(mif.fill_ready), 64'd0);
    check_output("rst_dren", 64'(mif.dREN), 64'd0);
    check_output("rst_dmissren", 64'(mif.dmissREN), 64'd0);
    check_output("rst_daddr", 64'(mif.daddr), 64'd0);
    check_output("rst_data", 64'(mif.fill_data), 64'd0);
    @(negedge clk);
    mif.nRST = 1'b1;

    run_fill(32'h0000_1234, 0, 1'b1, 0, 1'b1, 32'hAAAA_0000, 32'hBBBB_1111);
    idle_check();
    run_fill(32'h0000_1234, 5, 1'b1, 0, 1'b0, '0, '0);
    idle_check();
    run_fill(32'h0000_1234, 0, 1'b1, 2, 1'b0, '0, '0);
    idle_check();
    run_fill(32'hFFFF_FFF8, 0, 1'b1, 0, 1'b0, '0, '0);
    run_fill($urandom, 0, 1'b1, 0, 1'b0, '0, '0);
    idle_check();
    run_fill($urandom, 3, 1'b0, 0, 1'b0, '0, '0);
    run_fill($urandom, 4, 1'b1, 1, 1'b0, '0, '0);
    idle_check();

    // Reset while the second word is being fetched.
    @(negedge clk);
    mif.fill_req  = 1'b1;
    mif.fill_addr = 32'h0000_1234;
    mif.wempty    = 1'b1;
    mif.dwait     = 1'b0;
    @(negedge clk);
    mif.dload = $urandom;
    @(negedge clk);
    mif.dwait = 1'b1;
    #1;
    check_output("mid_daddr", 64'(mif.daddr), 64'h1234);
    #2;
    mif.nRST = 1'b0;
    #1;
    check_output("mid_rst_dren", 64'(mif.dREN), 64'd0);
    check_output("mid_rst_dmissren", 64'(mif.dmissREN), 64'd0);
    check_output("mid_rst_data", 64'(mif.fill_data), 64'd0);
    @(negedge clk);
    mif.nRST     = 1'b1;
    mif.fill_req = 1'b0;
    last_data    = '0;
    idle_check();

    for (int n = 0; n < 12; n++) begin
      run_fill($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1, 1'b0, '0, '0);
      if (n % 2 == 0) idle_check();
    end
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
